// File: rtl/alu_issue_unit_pkg.sv
// Shared opcode constants, default widths and the opcode legality check.
// No logic latency (constants and a pure function only).
// No backpressure (not a datapath element).
package alu_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int OPCODE_WIDTH   = 7;
    localparam int REG_ADDR_WIDTH = 3;
    localparam int ALU_LATENCY    = 3;

    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_OR   = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_SADD = 6;

    // Legal opcodes form the contiguous range ADD..SADD
    function automatic logic is_legal_opcode(input logic [31:0] op);
        return (op >= 32'(OP_ADD)) && (op <= 32'(OP_SADD));
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Bundles the instruction handshake, ALU issue/result, writeback, host and debug signals.
// No latency (wiring only).
// instr_valid/instr_ready handshake; the ALU side has no backpressure.
interface alu_issue_if #(
    parameter int data_width     = 32,
    parameter int opcode_width   = 7,
    parameter int reg_addr_width = 3
);
    logic                      instr_valid;
    logic                      instr_ready;
    logic [opcode_width-1:0]   instr_opcode;
    logic [reg_addr_width-1:0] instr_rd;
    logic [reg_addr_width-1:0] instr_rs1;
    logic [reg_addr_width-1:0] instr_rs2;

    logic                      alu_valid;
    logic [data_width-1:0]     alu_opA;
    logic [data_width-1:0]     alu_opB;
    logic [opcode_width-1:0]   alu_opcode;
    logic [data_width-1:0]     alu_result;

    logic                      wb_valid;
    logic [reg_addr_width-1:0] wb_addr;
    logic [data_width-1:0]     wb_data;

    logic                      host_wr_en;
    logic [reg_addr_width-1:0] host_wr_addr;
    logic [data_width-1:0]     host_wr_data;

    logic [reg_addr_width-1:0] dbg_addr;
    logic [data_width-1:0]     dbg_data;

    logic                      busy;
    logic                      illegal_op;

    // Issue unit side
    modport slave (
        input  instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2,
        input  alu_result, host_wr_en, host_wr_addr, host_wr_data, dbg_addr,
        output instr_ready, alu_valid, alu_opA, alu_opB, alu_opcode,
        output wb_valid, wb_addr, wb_data, dbg_data, busy, illegal_op
    );

    // Instruction source / ALU pipeline / host side
    modport master (
        output instr_valid, instr_opcode, instr_rd, instr_rs1, instr_rs2,
        output alu_result, host_wr_en, host_wr_addr, host_wr_data, dbg_addr,
        input  instr_ready, alu_valid, alu_opA, alu_opB, alu_opcode,
        input  wb_valid, wb_addr, wb_data, dbg_data, busy, illegal_op
    );

endinterface

// File: rtl/alu_issue_unit_regfile.sv
// Register file: three combinational read ports, one write port, r0 hardwired to zero.
// Reads are combinational; writes take effect at the end of the cycle.
// No backpressure: a write is always accepted (writes to r0 are discarded).
module alu_regfile #(
    parameter int data_width     = 32,
    parameter int reg_addr_width = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [reg_addr_width-1:0] ra1_i,
    input  logic [reg_addr_width-1:0] ra2_i,
    input  logic [reg_addr_width-1:0] ra3_i,
    output logic [data_width-1:0]     rd1_o,
    output logic [data_width-1:0]     rd2_o,
    output logic [data_width-1:0]     rd3_o,
    input  logic                      we_i,
    input  logic [reg_addr_width-1:0] waddr_i,
    input  logic [data_width-1:0]     wdata_i
);
    localparam int NREG = 1 << reg_addr_width;

    logic [data_width-1:0] rf_q [NREG];

    // Storage: cleared on reset, single write port that never touches r0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : rf_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : rf_q[ra2_i];
    assign rd3_o = (ra3_i == '0) ? '0 : rf_q[ra3_i];

endmodule

// File: rtl/alu_issue_unit.sv
// Issues register-addressed instructions to an external ALU pipeline and writes results back.
// Operands registered 1 cycle after acceptance; writeback alu_latency cycles after that.
// instr_ready drops combinationally while any of rs1/rs2/rd has a result outstanding.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int data_width     = DATA_WIDTH,
    parameter int opcode_width   = OPCODE_WIDTH,
    parameter int reg_addr_width = REG_ADDR_WIDTH,
    parameter int alu_latency    = ALU_LATENCY
) (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);
    localparam int NREG = 1 << reg_addr_width;

    logic [NREG-1:0]           pending_q;
    logic [NREG-1:0]           pending_d;
    logic                      alu_valid_q;
    logic [data_width-1:0]     alu_opA_q;
    logic [data_width-1:0]     alu_opB_q;
    logic [opcode_width-1:0]   alu_opcode_q;
    logic [reg_addr_width-1:0] iss_rd_q;
    logic                      illegal_q;
    logic [alu_latency-1:0]    tag_vld_q;
    logic [reg_addr_width-1:0] tag_rd_q [alu_latency];

    logic [data_width-1:0]     rs1_data;
    logic [data_width-1:0]     rs2_data;
    logic                      accept;
    logic                      legal;
    logic                      issue;
    logic                      wb_fire;
    logic [reg_addr_width-1:0] wb_rd;
    logic                      host_apply;
    logic                      rf_we;
    logic [reg_addr_width-1:0] rf_waddr;
    logic [data_width-1:0]     rf_wdata;

    // pending_q[0] is forced low, so r0 never causes a stall
    assign bus.instr_ready = !pending_q[bus.instr_rs1] && !pending_q[bus.instr_rs2]
                           && !pending_q[bus.instr_rd];
    assign accept  = bus.instr_valid && bus.instr_ready;
    assign legal   = is_legal_opcode(32'(bus.instr_opcode));
    assign issue   = accept && legal;

    assign wb_fire = tag_vld_q[alu_latency-1];
    assign wb_rd   = tag_rd_q[alu_latency-1];

    // The issue register counts as in flight too: an rd=0 instruction sets no
    // pending bit and has not yet reached the tag pipe in its issue cycle
    assign bus.busy = (|pending_q) || (|tag_vld_q) || alu_valid_q;

    // Host preload only lands in a fully idle cycle with no acceptance, so it
    // can never collide with a writeback on the single write port
    assign host_apply = bus.host_wr_en && !bus.busy && !accept;
    assign rf_we      = wb_fire || host_apply;
    assign rf_waddr   = wb_fire ? wb_rd : bus.host_wr_addr;
    assign rf_wdata   = wb_fire ? bus.alu_result : bus.host_wr_data;

    alu_regfile #(
        .data_width     (data_width),
        .reg_addr_width (reg_addr_width)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra1_i   (bus.instr_rs1),
        .ra2_i   (bus.instr_rs2),
        .ra3_i   (bus.dbg_addr),
        .rd1_o   (rs1_data),
        .rd2_o   (rs2_data),
        .rd3_o   (bus.dbg_data),
        .we_i    (rf_we),
        .waddr_i (rf_waddr),
        .wdata_i (rf_wdata)
    );

    // Scoreboard next state: clear on writeback, set on issue (WAW stall keeps them disjoint)
    always_comb begin
        pending_d = pending_q;
        if (wb_fire) begin
            pending_d[wb_rd] = 1'b0;
        end
        if (issue) begin
            pending_d[bus.instr_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Issue stage: capture operands/opcode on a legal acceptance, flag illegal ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_valid_q  <= 1'b0;
            alu_opA_q    <= '0;
            alu_opB_q    <= '0;
            alu_opcode_q <= '0;
            iss_rd_q     <= '0;
            illegal_q    <= 1'b0;
        end else begin
            alu_valid_q <= issue;
            illegal_q   <= accept && !legal;
            if (issue) begin
                alu_opA_q    <= rs1_data;
                alu_opB_q    <= rs2_data;
                alu_opcode_q <= bus.instr_opcode;
                iss_rd_q     <= bus.instr_rd;
            end
        end
    end

    // Tag pipe: follows each issued op through the ALU so its result is matched to rd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            for (int i = 0; i < alu_latency; i++) begin
                tag_rd_q[i] <= '0;
            end
        end else begin
            tag_vld_q[0] <= alu_valid_q;
            tag_rd_q[0]  <= iss_rd_q;
            for (int i = 1; i < alu_latency; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_rd_q[i]  <= tag_rd_q[i-1];
            end
        end
    end

    assign bus.alu_valid  = alu_valid_q;
    assign bus.alu_opA    = alu_opA_q;
    assign bus.alu_opB    = alu_opB_q;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.illegal_op = illegal_q;
    assign bus.wb_valid   = wb_fire;
    assign bus.wb_addr    = wb_rd;
    assign bus.wb_data    = bus.alu_result;

endmodule

// File: tb/tb_alu_issue_unit.sv
module tb_alu_issue_unit;
    import alu_pkg::*;

    localparam int L = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Architectural ALU semantics (SADD = signed saturating add)
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint s;
        case (op)
            1: return a + b;
            2: return a - b;
            3: return a & b;
            4: return a | b;
            5: return a ^ b;
            6: begin
                s = longint'($signed(a)) + longint'($signed(b));
                if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
                if (s < -64'sd2147483648) return 32'h8000_0000;
                return 32'(s);
            end
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // External ALU pipeline of fixed latency L; not reset, so stale results keep arriving
    logic [31:0] alu_pipe [L] = '{default: 32'h0};
    always @(posedge clk) begin
        alu_pipe[0] <= bus.alu_valid ? ref_alu(int'(bus.alu_opcode), bus.alu_opA, bus.alu_opB)
                                     : 32'hBAD0_BAD0;
        for (int i = 1; i < L; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign bus.alu_result = alu_pipe[L-1];

    // Reference model: architectural register file updated at acceptance, plus
    // queues of expected issue beats and timed writebacks
    typedef struct { logic [31:0] a; logic [31:0] b; logic [6:0] op; } iss_t;
    typedef struct { logic [2:0] rd; logic [31:0] data; int due; } wb_t;

    logic [31:0] mrf [8] = '{default: 32'h0};
    iss_t iss_q[$];
    wb_t  wb_q[$];
    int   cyc = 0;
    bit   ill_exp = 0;
    bit   m_busy, m_ready, m_acc, m_legal, exp_wb;
    logic [7:0]  m_pend;
    logic [31:0] m_a, m_b, m_res;
    iss_t it;
    wb_t  wt;

    // Monitor/scoreboard: predicts handshake state from outstanding work, checks every output
    always @(negedge clk) begin
        if (!rst_n) begin
            iss_q.delete();
            wb_q.delete();
            ill_exp = 0;
            for (int i = 0; i < 8; i++) mrf[i] = 32'h0;
        end else begin
            m_busy = (wb_q.size() != 0);
            m_pend = 8'h0;
            foreach (wb_q[i]) if (wb_q[i].rd != 3'd0) m_pend[wb_q[i].rd] = 1'b1;
            m_ready = !m_pend[bus.instr_rs1] && !m_pend[bus.instr_rs2] && !m_pend[bus.instr_rd];
            check("busy", bus.busy, m_busy);
            check("instr_ready", bus.instr_ready, m_ready);

            check("alu_valid", bus.alu_valid, iss_q.size() != 0);
            if (iss_q.size() != 0) begin
                it = iss_q.pop_front();
                check("alu_opA", bus.alu_opA, it.a);
                check("alu_opB", bus.alu_opB, it.b);
                check("alu_opcode", bus.alu_opcode, it.op);
            end

            exp_wb = 0;
            if (wb_q.size() != 0) exp_wb = (wb_q[0].due == cyc);
            check("wb_valid", bus.wb_valid, exp_wb);
            if (exp_wb) begin
                wt = wb_q.pop_front();
                check("wb_addr", bus.wb_addr, wt.rd);
                check("wb_data", bus.wb_data, wt.data);
            end

            check("illegal_op", bus.illegal_op, ill_exp);
            ill_exp = 0;

            m_acc = bus.instr_valid && bus.instr_ready;
            if (m_acc) begin
                m_legal = (bus.instr_opcode >= 7'd1) && (bus.instr_opcode <= 7'd6);
                if (m_legal) begin
                    m_a   = mrf[bus.instr_rs1];
                    m_b   = mrf[bus.instr_rs2];
                    m_res = ref_alu(int'(bus.instr_opcode), m_a, m_b);
                    iss_q.push_back('{a: m_a, b: m_b, op: bus.instr_opcode});
                    wb_q.push_back('{rd: bus.instr_rd, data: m_res, due: cyc + 1 + L});
                    if (bus.instr_rd != 3'd0) mrf[bus.instr_rd] = m_res;
                end else begin
                    ill_exp = 1;
                end
            end
            if (bus.host_wr_en && !m_busy && !m_acc && bus.host_wr_addr != 3'd0)
                mrf[bus.host_wr_addr] = bus.host_wr_data;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input int addr, input logic [31:0] data);
        bus.host_wr_en   = 1'b1;
        bus.host_wr_addr = 3'(addr);
        bus.host_wr_data = data;
        step();
        bus.host_wr_en   = 1'b0;
    endtask

    task automatic set_instr(input int op, input int rd, input int rs1, input int rs2);
        bus.instr_opcode = 7'(op);
        bus.instr_rd     = 3'(rd);
        bus.instr_rs1    = 3'(rs1);
        bus.instr_rs2    = 3'(rs2);
        bus.instr_valid  = 1'b1;
    endtask

    task automatic send(input int op, input int rd, input int rs1, input int rs2);
        int n = 0;
        set_instr(op, rd, rs1, rs2);
        @(negedge clk);
        while (!bus.instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: instr_ready low for %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy stayed 1 for %0d cycles, expected 0", n);
        end
        step();
    endtask

    task automatic check_rf(input string name, input bit zero);
        for (int a = 0; a < 8; a++) begin
            bus.dbg_addr = 3'(a);
            #1;
            check(name, bus.dbg_data, zero ? 32'h0 : mrf[a]);
        end
        step();
    endtask

    int cnt_alu, cnt_wb, cnt_ill, n, op;
    logic [31:0] vals [4];

    initial begin
        bus.instr_valid = 0; bus.instr_opcode = 0; bus.instr_rd = 0;
        bus.instr_rs1 = 0; bus.instr_rs2 = 0;
        bus.host_wr_en = 0; bus.host_wr_addr = 0; bus.host_wr_data = 0; bus.dbg_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.instr_ready, 1);
        check("rst_alu_valid", bus.alu_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_illegal", bus.illegal_op, 0);
        rst_n = 1'b1;
        check_rf("rst_rf", 1);

        // ADD r3,r1,r2 then dependent SUB r4,r3,r1 offered right behind it
        host_wr(1, 32'd5);
        host_wr(2, 32'd3);
        set_instr(OP_ADD, 3, 1, 2);
        @(negedge clk);
        check("add_ready", bus.instr_ready, 1);
        step();
        set_instr(OP_SUB, 4, 3, 1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("raw_stall", bus.instr_ready, 0);
            if (k == 1) begin
                check("add_opA", bus.alu_opA, 5);
                check("add_opB", bus.alu_opB, 3);
                check("add_opcode", bus.alu_opcode, 1);
            end
            if (k == 4) begin
                check("add_wb_valid", bus.wb_valid, 1);
                check("add_wb_addr", bus.wb_addr, 3);
                check("add_wb_data", bus.wb_data, 8);
            end
            step();
        end
        @(negedge clk);
        check("raw_release", bus.instr_ready, 1);
        step();
        bus.instr_valid = 1'b0;
        wait_idle();
        bus.dbg_addr = 3'd4;
        #1;
        check("sub_result_r4", bus.dbg_data, 3);

        // Four independent ADDs back to back
        step();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_instr(OP_ADD, 4, 1, 2);
                1: set_instr(OP_ADD, 5, 1, 1);
                2: set_instr(OP_ADD, 6, 2, 2);
                default: set_instr(OP_ADD, 7, 1, 3);
            endcase
            @(negedge clk);
            check("indep_ready", bus.instr_ready, 1);
            step();
        end
        bus.instr_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.wb_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            check("burst_wb_valid", bus.wb_valid, 1);
            check("burst_wb_addr", bus.wb_addr, 32'(4 + i));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        wait_idle();

        // Signed saturating add wrapping to zero
        host_wr(1, 32'hFFFF_FFFF);
        host_wr(2, 32'd1);
        send(OP_SADD, 5, 1, 2);
        wait_idle();
        bus.dbg_addr = 3'd5;
        #1;
        check("sadd_r5", bus.dbg_data, 0);

        // Illegal opcode: one pulse, nothing issued or written
        step();
        send(0, 6, 1, 2);
        cnt_alu = 0; cnt_wb = 0; cnt_ill = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            cnt_alu += int'(bus.alu_valid);
            cnt_wb  += int'(bus.wb_valid);
            cnt_ill += int'(bus.illegal_op);
        end
        check("illegal_alu_valid_cnt", cnt_alu, 0);
        check("illegal_wb_cnt", cnt_wb, 0);
        check("illegal_pulse_cnt", cnt_ill, 1);
        bus.dbg_addr = 3'd6;
        #1;
        check("illegal_r6_kept", bus.dbg_data, 6);
        step();

        // Writes to r0 vanish
        send(OP_ADD, 0, 6, 6);
        wait_idle();
        bus.dbg_addr = 3'd0;
        #1;
        check("r0_zero", bus.dbg_data, 0);
        step();

        // Reset with two instructions in flight
        host_wr(1, 32'd7);
        send(OP_ADD, 4, 1, 1);
        send(OP_ADD, 5, 1, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.busy, 0);
        check("midrst_ready", bus.instr_ready, 1);
        check("midrst_alu_valid", bus.alu_valid, 0);
        check("midrst_wb_valid", bus.wb_valid, 0);
        step();
        step();
        rst_n = 1'b1;
        cnt_wb = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            cnt_wb += int'(bus.wb_valid);
        end
        check("midrst_no_wb", cnt_wb, 0);
        @(posedge clk);
        #1;
        check_rf("midrst_rf", 1);

        // Randomized traffic against the reference model
        vals[0] = 32'h7FFF_FFFF; vals[1] = 32'h8000_0000; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h1;
        for (int r = 1; r < 8; r++)
            host_wr(r, ($urandom_range(0, 1) == 0) ? $urandom : vals[$urandom_range(0, 3)]);
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 7) == 0)
                host_wr($urandom_range(0, 7), $urandom);
            n = $urandom_range(0, 9);
            op = (n < 8) ? n : $urandom_range(8, 127);
            send(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        end
        wait_idle();
        check_rf("final_rf", 0);
        check("wb_queue_drained", wb_q.size(), 0);
        check("iss_queue_drained", iss_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
